// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - vector instruction sequencer: fetch, decode, per-element issue
//
// Purpose: fetches 16-bit instructions from an external instruction memory
// and replays each vector instruction once per element toward the vector
// control unit. NOP advances the PC without issuing; HALT ends the program
// with a one-cycle done pulse. Datapath backpressure freezes element issue.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   start      - launch a program (sampled only while idle)
//   prog_base  - program start address, captured with start
//   imem_addr  - instruction fetch address
//   imem_rd    - fetch strobe; imem_data returns one cycle later
//   imem_data  - instruction word: [15:13] opcode, [12:0] operand
//   stall      - datapath not ready; holds the sequencer while issuing
//   op_code    - opcode to the control unit (NOP encoding when not issuing)
//   operand    - operand field of the current instruction
//   elem_idx   - element currently being issued
//   issue      - op_code/operand/elem_idx valid this cycle
//   busy       - high whenever not idle
//   done       - one-cycle pulse on program completion

module vector_sequencer #(
  parameter int IADDR_W = 8,
  parameter int VLEN    = 8,
  parameter int EIDX_W  = $clog2(VLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IADDR_W-1:0] prog_base,
  output logic [IADDR_W-1:0] imem_addr,
  output logic               imem_rd,
  input  logic [15:0]        imem_data,
  input  logic               stall,
  output logic [2:0]         op_code,
  output logic [12:0]        operand,
  output logic [EIDX_W-1:0]  elem_idx,
  output logic               issue,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0]        OP_NOP    = 3'b010;
  localparam logic [2:0]        OP_HALT   = 3'b011;
  localparam logic [EIDX_W-1:0] EIDX_LAST = EIDX_W'(VLEN - 1);

  state_t             state, state_nxt;
  logic [IADDR_W-1:0] pc, pc_nxt;
  logic [EIDX_W-1:0]  eidx, eidx_nxt;
  logic [2:0]         ir_op, ir_op_nxt;
  logic [12:0]        ir_opd, ir_opd_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      eidx   <= '0;
      ir_op  <= OP_NOP;
      ir_opd <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      eidx   <= eidx_nxt;
      ir_op  <= ir_op_nxt;
      ir_opd <= ir_opd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    eidx_nxt   = eidx;
    ir_op_nxt  = ir_op;
    ir_opd_nxt = ir_opd;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = prog_base;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        // imem_data is the registered response to last cycle's fetch strobe.
        ir_op_nxt  = imem_data[15:13];
        ir_opd_nxt = imem_data[12:0];
        case (imem_data[15:13])
          OP_HALT: state_nxt = S_DONE;
          OP_NOP: begin
            pc_nxt    = pc + IADDR_W'(1);
            state_nxt = S_FETCH;
          end
          default: begin
            eidx_nxt  = '0;
            state_nxt = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        if (!stall) begin
          if (eidx == EIDX_LAST) begin
            pc_nxt    = pc + IADDR_W'(1);
            state_nxt = S_FETCH;
          end else begin
            eidx_nxt = eidx + EIDX_W'(1);
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign imem_rd   = (state == S_FETCH);
  assign issue     = (state == S_ISSUE);
  // Outside issue the control unit sees the NOP encoding, which keeps all
  // of its write enables and mux selects deasserted.
  assign op_code   = issue ? ir_op : OP_NOP;
  assign operand   = ir_opd;
  assign elem_idx  = eidx;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
